pe_program_loader: RTL and testbench

- Upstream control stage for the single-cycle vector processing element (PE).
- Accepts a 32-bit instruction stream over a valid/ready handshake and writes it into the instruction memory's write port.
- Holds the PE in reset while loading, then releases it and monitors the PE program counter.
- Signals completion when the PE runs off the end of the loaded program, or a timeout when a cycle limit expires.

---
 rtl/pe_loader_pkg.sv | 14 +
 rtl/pe_program_loader_if.sv | 13 +
 rtl/pe_program_loader.sv | 151 +++++++++++++++
 tb/tb_pe_program_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_loader_pkg.sv
// Shared types and constants for the PE program loader.
package pe_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = 4;

endpackage

// File: rtl/pe_program_loader_if.sv
// Instruction stream valid/ready handshake between a producer and the loader.
interface pe_program_loader_if;
  import pe_loader_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [INSTR_W-1:0] s_data;
  logic               s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/pe_program_loader.sv
// Streams a program into instruction memory with the PE held in reset, then
// releases the PE and watches its PC for normal completion or a cycle limit.
module pe_program_loader
  import pe_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  pe_program_loader_if.slave  s_if,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_wdata,
  output logic                pe_rst,
  input  logic [INSTR_W-1:0]  pe_pc,
  input  logic [CNT_W-1:0]    max_cycles,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic                err_overflow,
  output logic [ADDR_W:0]     word_count,
  output logic [CNT_W-1:0]    cycle_count
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(IMEM_DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_e               state_q, state_d;
  logic [ADDR_W:0]      word_count_q, word_count_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]     max_q, max_d;
  logic                 imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]    imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0]   imem_wdata_q, imem_wdata_d;
  logic                 pe_rst_q, pe_rst_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 err_overflow_q, err_overflow_d;

  logic                 start_ok, xfer, overflow, pc_hit, limit_hit;
  logic [INSTR_W-1:0]   end_addr;

  assign s_if.s_ready = (state_q == LOAD) && (word_count_q < DEPTH_W);
  assign xfer         = s_if.s_valid && s_if.s_ready;
  assign overflow     = (state_q == LOAD) && s_if.s_valid && (word_count_q == DEPTH_W);
  assign start_ok     = start && ((state_q == IDLE) || (state_q == DONE));
  assign end_addr     = INSTR_W'(word_count_q) * INSTR_W'(BYTES_PER_INSTR);

  // A zero cycle count marks the first RUN cycle, where the PC is still settling.
  assign pc_hit    = (state_q == RUN) && (cycle_count_q != '0) && (pe_pc == end_addr);
  assign limit_hit = (state_q == RUN) && (max_q != '0) &&
                     (({1'b0, cycle_count_q} + (CNT_W+1)'(1)) == {1'b0, max_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      word_count_q   <= '0;
      cycle_count_q  <= '0;
      max_q          <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      pe_rst_q       <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_count_q   <= word_count_d;
      cycle_count_q  <= cycle_count_d;
      max_q          <= max_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      pe_rst_q       <= pe_rst_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD: begin
        if (xfer && s_if.s_last) state_d = RUN;
        else if (overflow)       state_d = DONE;
      end
      RUN:     if (pc_hit || limit_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_count_d   = word_count_q;
    cycle_count_d  = cycle_count_q;
    max_d          = max_q;
    imem_we_d      = xfer;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    done_d         = done_q;
    timeout_d      = timeout_q;
    err_overflow_d = err_overflow_q;

    if (start_ok) begin
      word_count_d   = '0;
      cycle_count_d  = '0;
      done_d         = 1'b0;
      timeout_d      = 1'b0;
      err_overflow_d = 1'b0;
      max_d          = max_cycles;
    end
    if (xfer) begin
      imem_addr_d  = word_count_q[ADDR_W-1:0];
      imem_wdata_d = s_if.s_data;
      word_count_d = word_count_q + (ADDR_W+1)'(1);
    end
    if (overflow) err_overflow_d = 1'b1;
    if (state_q == RUN) begin
      cycle_count_d = sat_inc(cycle_count_q);
      // Normal completion takes priority over the cycle limit.
      if (pc_hit)         done_d    = 1'b1;
      else if (limit_hit) timeout_d = 1'b1;
    end

    pe_rst_d = (state_d != RUN);
    busy_d   = (state_d == LOAD) || (state_d == RUN);
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign pe_rst       = pe_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign err_overflow = err_overflow_q;
  assign word_count   = word_count_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_pe_program_loader.sv
// Bench for pe_program_loader: table of load/run scenarios plus hand-written
// overflow and reset sequences, with a write scoreboard on the imem port.
module tb_pe_program_loader;
  import pe_loader_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CW    = 32;

  logic            clk = 1'b0;
  logic            rst, start;
  logic            imem_we, pe_rst, busy, done, timeout, err_overflow;
  logic [AW-1:0]   imem_addr;
  logic [31:0]     imem_wdata, pe_pc;
  logic [CW-1:0]   max_cycles, cycle_count;
  logic [AW:0]     word_count;

  pe_program_loader_if s_if();

  pe_program_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .s_if(s_if),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .pe_rst(pe_rst), .pe_pc(pe_pc), .max_cycles(max_cycles),
    .busy(busy), .done(done), .timeout(timeout), .err_overflow(err_overflow),
    .word_count(word_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write scoreboard: each accepted word is queued with its expected address.
  typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];
  int  exp_wc  = 0;
  int  wr_cnt  = 0;
  bit  xfer_seen = 1'b0;
  bit  mon_en    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_wc    = 0;
      xfer_seen = 1'b0;
    end else begin
      xfer_seen = s_if.s_valid && s_if.s_ready;
      if (xfer_seen) begin
        exp_q.push_back('{addr: AW'(exp_wc), data: s_if.s_data});
        exp_wc++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_one_cycle_after_xfer", imem_we, xfer_seen);
      if (imem_we === 1'b1) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", imem_addr, e.addr);
          chk("wr_data", imem_wdata, e.data);
        end
      end
    end
  end

  logic [31:0] words [8] = '{32'h00500093, 32'h00108113, 32'h002081B3, 32'h00000013,
                             32'h00A00193, 32'h40318233, 32'h0041A023, 32'hFFF00293};

  // pc_mode: 0 = hold 0, 1 = step 4 per RUN cycle from 0, 2 = hold END
  typedef struct {
    string         name;
    int            nwords;
    bit            bubbles;
    logic [CW-1:0] maxc;
    int            pc_mode;
    bit            exp_done;
    bit            exp_to;
    logic [CW-1:0] exp_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk_reset_vals(input string p);
    chk({p, "_s_ready"}, s_if.s_ready, 0);
    chk({p, "_imem_we"}, imem_we, 0);
    chk({p, "_imem_addr"}, imem_addr, 0);
    chk({p, "_imem_wdata"}, imem_wdata, 0);
    chk({p, "_pe_rst"}, pe_rst, 1);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_timeout"}, timeout, 0);
    chk({p, "_err_overflow"}, err_overflow, 0);
    chk({p, "_word_count"}, word_count, 0);
    chk({p, "_cycle_count"}, cycle_count, 0);
  endtask

  task automatic do_start(input logic [CW-1:0] m);
    @(negedge clk);
    exp_wc     = 0;
    max_cycles = m;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    max_cycles = 32'h0000_0002;   // must not affect the latched limit
    chk("start_busy", busy, 1);
    chk("start_pe_rst", pe_rst, 1);
    chk("start_flags", {done, timeout, err_overflow}, 0);
    chk("start_counts", {word_count, cycle_count}, 0);
  endtask

  task automatic load_words(input int n, input bit bub);
    for (int i = 0; i < n; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = words[i];
      s_if.s_last  = (i == n - 1);
      #1 chk("load_ready", s_if.s_ready, 1);
      @(negedge clk);
      if (bub && i != n - 1) begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = $urandom;
        s_if.s_last  = 1'b1;
        @(negedge clk);
      end
    end
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    int wr0;
    wr0 = wr_cnt;
    do_start(v.maxc);
    load_words(v.nwords, v.bubbles);
    chk({v.name, "_pe_rst_first_run"}, pe_rst, 0);
    k = 1;
    while (busy === 1'b1 && k < 100) begin
      pe_pc = (v.pc_mode == 1) ? 32'(4 * (k - 1)) :
              (v.pc_mode == 2) ? 32'(4 * v.nwords) : 32'h0;
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk({v.name, "_run_bound"}, 0, 1);
    pe_pc = 32'h0;
    chk({v.name, "_done"}, done, v.exp_done);
    chk({v.name, "_timeout"}, timeout, v.exp_to);
    chk({v.name, "_cycle_count"}, cycle_count, v.exp_cyc);
    chk({v.name, "_word_count"}, word_count, v.nwords);
    chk({v.name, "_pe_rst_end"}, pe_rst, 1);
    chk({v.name, "_err_overflow"}, err_overflow, 0);
    chk({v.name, "_writes"}, wr_cnt - wr0, v.nwords);
    chk({v.name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr0;
    vecs[0] = '{"basic",     4, 1'b0, 0,  1, 1'b1, 1'b0, 5};
    vecs[1] = '{"bubbles",   3, 1'b1, 0,  1, 1'b1, 1'b0, 4};
    vecs[2] = '{"timeout",   2, 1'b0, 10, 0, 1'b0, 1'b1, 10};
    vecs[3] = '{"both",      2, 1'b0, 3,  1, 1'b1, 1'b0, 3};
    vecs[4] = '{"single",    1, 1'b0, 0,  1, 1'b1, 1'b0, 2};
    vecs[5] = '{"full",      8, 1'b0, 0,  1, 1'b1, 1'b0, 9};
    vecs[6] = '{"limit1",    2, 1'b0, 1,  0, 1'b0, 1'b1, 1};
    vecs[7] = '{"pc_first",  3, 1'b0, 0,  2, 1'b1, 1'b0, 2};

    rst = 1'b1; start = 1'b0; pe_pc = 32'h0; max_cycles = '0;
    s_if.s_valid = 1'b0; s_if.s_data = 32'h0; s_if.s_last = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("idle");

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Overflow: nine words without last into an eight-word memory
    wr0 = wr_cnt;
    do_start(0);
    for (int i = 0; i < DEPTH; i++) begin
      s_if.s_valid = 1'b1; s_if.s_data = words[i]; s_if.s_last = 1'b0;
      #1 chk("ovf_ready", s_if.s_ready, 1);
      @(negedge clk);
    end
    s_if.s_valid = 1'b1; s_if.s_data = 32'hBAD0BAD0; s_if.s_last = 1'b0;
    #1 chk("ovf_ready_low", s_if.s_ready, 0);
    chk("ovf_wc_full", word_count, DEPTH);
    @(negedge clk);
    s_if.s_valid = 1'b0;
    chk("ovf_err", err_overflow, 1);
    chk("ovf_done", done, 0);
    chk("ovf_timeout", timeout, 0);
    chk("ovf_busy", busy, 0);
    chk("ovf_pe_rst", pe_rst, 1);
    chk("ovf_wc", word_count, DEPTH);
    @(negedge clk);
    chk("ovf_writes", wr_cnt - wr0, DEPTH);
    chk("ovf_sb_empty", exp_q.size(), 0);

    // Reset mid-RUN, with a start pulse that must be ignored while running
    do_start(0);
    load_words(2, 1'b0);
    pe_pc = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_start_ignored_busy", busy, 1);
    chk("run_start_ignored_pe_rst", pe_rst, 0);
    chk("run_start_ignored_cyc", cycle_count, 1);
    chk("run_start_ignored_wc", word_count, 2);
    repeat (3) @(negedge clk);
    chk("pre_rst_cyc", cycle_count, 4);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
